// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown timer: FSM states, BCD limits
// and the single-digit BCD decrement used by the borrow chain.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam logic [3:0] MAX_UNITS   = 4'd9;
  localparam logic [3:0] MAX_TENS_MS = 4'd5;
  localparam logic [7:0] MAX_HOUR    = 8'd23;

  // Returns {borrow, digit}; a zero digit wraps to limit and requests a borrow.
  function automatic logic [4:0] bcd_dec(input logic [3:0] digit, input logic [3:0] limit);
    logic [4:0] res;
    if (digit == 4'd0) begin
      res = {1'b1, limit};
    end else begin
      res = {1'b0, digit - 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_regressivo_divisor.sv
// Prescaler for the countdown timer: counts 0..CLK_HZ-1 while enabled and
// flags the last cycle of each period as a tick.
module divisor_1hz #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_r;

  // Phase counter; holds its value whenever en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= (cnt_r == LAST) ? '0 : cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/timer_regressivo.sv
// Countdown timer core: loads a validated HH:MM:SS value, counts down once
// per prescaler tick, and raises an alarm when the count reaches 00:00:00.
module timer_regressivo
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       start_pause,
  input  logic       clear,
  input  logic [3:0] ajuste_timer_hour_tens,
  input  logic [3:0] ajuste_timer_hour_units,
  input  logic [3:0] ajuste_timer_min_tens,
  input  logic [3:0] ajuste_timer_min_units,
  input  logic [3:0] ajuste_timer_sec_tens,
  input  logic [3:0] ajuste_timer_sec_units,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       running,
  output logic       alarme,
  output logic       fim,
  output logic       load_err
);

  timer_state_t state_r;

  logic       tick_s;
  logic       en_s;
  logic       clr_s;
  logic [4:0] borrow_s;
  logic [3:0] dec_ht_s, dec_hu_s, dec_mt_s, dec_mu_s, dec_st_s, dec_su_s;
  logic       dec_zero_s;
  logic       count_zero_s;
  logic [7:0] hour_val_s;
  logic       load_ok_s;

  // The prescaler only runs in RUN and sits at zero outside RUN/PAUSE, so a
  // start from IDLE always begins a full period.
  assign en_s  = (state_r == RUN) && !clear;
  assign clr_s = clear || (state_r == IDLE) || (state_r == DONE);

  divisor_1hz #(
    .CLK_HZ(CLK_HZ)
  ) u_divisor (
    .clk (clk),
    .rst (rst),
    .en  (en_s),
    .clr (clr_s),
    .tick(tick_s)
  );

  // BCD borrow chain producing the count one second lower.
  always_comb begin
    {borrow_s[0], dec_su_s} = bcd_dec(sec_units, MAX_UNITS);
    if (borrow_s[0]) begin
      {borrow_s[1], dec_st_s} = bcd_dec(sec_tens, MAX_TENS_MS);
    end else begin
      borrow_s[1] = 1'b0;
      dec_st_s    = sec_tens;
    end
    if (borrow_s[1]) begin
      {borrow_s[2], dec_mu_s} = bcd_dec(min_units, MAX_UNITS);
    end else begin
      borrow_s[2] = 1'b0;
      dec_mu_s    = min_units;
    end
    if (borrow_s[2]) begin
      {borrow_s[3], dec_mt_s} = bcd_dec(min_tens, MAX_TENS_MS);
    end else begin
      borrow_s[3] = 1'b0;
      dec_mt_s    = min_tens;
    end
    if (borrow_s[3]) begin
      {borrow_s[4], dec_hu_s} = bcd_dec(hour_units, MAX_UNITS);
    end else begin
      borrow_s[4] = 1'b0;
      dec_hu_s    = hour_units;
    end
    if (borrow_s[4]) begin
      dec_ht_s = hour_tens - 4'd1;
    end else begin
      dec_ht_s = hour_tens;
    end
  end

  assign dec_zero_s   = ({dec_ht_s, dec_hu_s, dec_mt_s, dec_mu_s, dec_st_s, dec_su_s} == 24'd0);
  assign count_zero_s = ({hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units} == 24'd0);

  // Load validation: BCD digits, minutes/seconds below 60, hours below 24.
  always_comb begin
    hour_val_s = ({4'd0, ajuste_timer_hour_tens} * 8'd10) + {4'd0, ajuste_timer_hour_units};
    load_ok_s  = (ajuste_timer_hour_tens  <= MAX_UNITS)   &&
                 (ajuste_timer_hour_units <= MAX_UNITS)   &&
                 (ajuste_timer_min_tens   <= MAX_TENS_MS) &&
                 (ajuste_timer_min_units  <= MAX_UNITS)   &&
                 (ajuste_timer_sec_tens   <= MAX_TENS_MS) &&
                 (ajuste_timer_sec_units  <= MAX_UNITS)   &&
                 (hour_val_s <= MAX_HOUR);
  end

  // Timer FSM with registered digits and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      hour_tens  <= 4'd0;
      hour_units <= 4'd0;
      min_tens   <= 4'd0;
      min_units  <= 4'd0;
      sec_tens   <= 4'd0;
      sec_units  <= 4'd0;
      running    <= 1'b0;
      alarme     <= 1'b0;
      fim        <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      fim      <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        state_r    <= IDLE;
        hour_tens  <= 4'd0;
        hour_units <= 4'd0;
        min_tens   <= 4'd0;
        min_units  <= 4'd0;
        sec_tens   <= 4'd0;
        sec_units  <= 4'd0;
        running    <= 1'b0;
        alarme     <= 1'b0;
      end else if (load && (state_r != RUN)) begin
        if (load_ok_s) begin
          state_r    <= IDLE;
          hour_tens  <= ajuste_timer_hour_tens;
          hour_units <= ajuste_timer_hour_units;
          min_tens   <= ajuste_timer_min_tens;
          min_units  <= ajuste_timer_min_units;
          sec_tens   <= ajuste_timer_sec_tens;
          sec_units  <= ajuste_timer_sec_units;
          running    <= 1'b0;
          alarme     <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (start_pause) begin
        // A coincident tick in RUN is dropped here on purpose.
        case (state_r)
          IDLE: begin
            if (!count_zero_s) begin
              state_r <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            state_r <= PAUSE;
            running <= 1'b0;
          end
          PAUSE: begin
            state_r <= RUN;
            running <= 1'b1;
          end
          DONE: begin
            state_r <= IDLE;
            alarme  <= 1'b0;
          end
          default: begin
            state_r <= IDLE;
            running <= 1'b0;
            alarme  <= 1'b0;
          end
        endcase
      end else if ((state_r == RUN) && tick_s) begin
        hour_tens  <= dec_ht_s;
        hour_units <= dec_hu_s;
        min_tens   <= dec_mt_s;
        min_units  <= dec_mu_s;
        sec_tens   <= dec_st_s;
        sec_units  <= dec_su_s;
        if (dec_zero_s) begin
          state_r <= DONE;
          running <= 1'b0;
          alarme  <= 1'b1;
          fim     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_regressivo.sv
// Self-checking bench for timer_regressivo: a seconds-based reference model
// checked every cycle, a directed vector table, corner sequences and random traffic.
module tb_timer_regressivo;

  localparam int CLK = 4;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        start_pause = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] adj = 24'd0;
  logic [3:0]  hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units;
  logic        running, alarme, fim, load_err;

  always #5 clk = ~clk;

  timer_regressivo #(.CLK_HZ(CLK)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .load                   (load),
    .start_pause            (start_pause),
    .clear                  (clear),
    .ajuste_timer_hour_tens (adj[23:20]),
    .ajuste_timer_hour_units(adj[19:16]),
    .ajuste_timer_min_tens  (adj[15:12]),
    .ajuste_timer_min_units (adj[11:8]),
    .ajuste_timer_sec_tens  (adj[7:4]),
    .ajuste_timer_sec_units (adj[3:0]),
    .hour_tens              (hour_tens),
    .hour_units             (hour_units),
    .min_tens               (min_tens),
    .min_units              (min_units),
    .sec_tens               (sec_tens),
    .sec_units              (sec_units),
    .running                (running),
    .alarme                 (alarme),
    .fim                    (fim),
    .load_err               (load_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: count kept as total seconds, prescaler as a phase number.
  int m_secs  = 0;
  int m_state = S_IDLE;
  int m_phase = 0;
  bit m_alarm = 1'b0;
  bit m_fim   = 1'b0;
  bit m_lerr  = 1'b0;

  function automatic logic [23:0] digits();
    return {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};
  endfunction

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic bit valid_load(input logic [23:0] v);
    int d [6];
    for (int i = 0; i < 6; i++) d[i] = int'(v[23-4*i -: 4]);
    for (int i = 0; i < 6; i++) if (d[i] > 9) return 1'b0;
    if (d[2] > 5 || d[4] > 5) return 1'b0;
    return (d[0] * 10 + d[1]) <= 23;
  endfunction

  function automatic int to_secs(input logic [23:0] v);
    return (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 +
           (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
           int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick;
    tick   = (m_state == S_RUN) && (m_phase == CLK - 1);
    m_fim  = 1'b0;
    m_lerr = 1'b0;
    if (rst) begin
      m_secs = 0; m_state = S_IDLE; m_phase = 0; m_alarm = 1'b0;
    end else if (clear) begin
      m_secs = 0; m_state = S_IDLE; m_phase = 0; m_alarm = 1'b0;
    end else if (load && m_state != S_RUN) begin
      if (valid_load(adj)) begin
        m_secs = to_secs(adj); m_state = S_IDLE; m_alarm = 1'b0;
      end else begin
        m_lerr = 1'b1;
      end
    end else if (start_pause) begin
      case (m_state)
        S_IDLE:  if (m_secs != 0) begin m_state = S_RUN; m_phase = 0; end
        S_RUN:   begin m_state = S_PAUSE; m_phase = (m_phase + 1) % CLK; end
        S_PAUSE: m_state = S_RUN;
        default: begin m_state = S_IDLE; m_alarm = 1'b0; end
      endcase
    end else if (m_state == S_RUN) begin
      m_phase = (m_phase + 1) % CLK;
      if (tick) begin
        m_secs--;
        if (m_secs == 0) begin m_state = S_DONE; m_alarm = 1'b1; m_fim = 1'b1; end
      end
    end
  endtask

  // One clock: advance the model with the current inputs, then compare after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("model_digits",   digits(), to_bcd(m_secs));
    check("model_running",  24'(running),  24'(m_state == S_RUN));
    check("model_alarme",   24'(alarme),   24'(m_alarm));
    check("model_fim",      24'(fim),      24'(m_fim));
    check("model_load_err", 24'(load_err), 24'(m_lerr));
  endtask

  task automatic pulse(input logic r, input logic c, input logic l, input logic s, input logic [23:0] v);
    rst = r; clear = c; load = l; start_pause = s; adj = v;
    cycle();
    rst = 1'b0; clear = 1'b0; load = 1'b0; start_pause = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    logic        clr;
    logic        ld;
    logic        sp;
    logic [23:0] val;
    int          wait_n;
    logic [23:0] exp_digits;
    logic        exp_run;
    logic        exp_alarm;
    logic        exp_lerr;
  } vec_t;

  vec_t vecs [17];
  int   fim_count;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 24'h000003, 0, 24'h000003, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 24'h000000, 0, 24'h000003, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 3, 24'h000002, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 3, 24'h000001, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 3, 24'h000000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 5, 24'h000000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 0, 24'h000000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 24'h240000, 0, 24'h000000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 24'h010000, 0, 24'h010000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 24'h000000, 4, 24'h005959, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 24'h000000, 0, 24'h005959, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 24'h006000, 0, 24'h005959, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 24'h200000, 0, 24'h200000, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 24'h000000, 4, 24'h195959, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 24'h123456, 0, 24'h195959, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 24'h123456, 0, 24'h000000, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 24'h000000, 2, 24'h000000, 1'b0, 1'b0, 1'b0};

    // Reset for two cycles.
    @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
    check("reset_digits",   digits(),       24'h000000);
    check("reset_running",  24'(running),   24'h0);
    check("reset_alarme",   24'(alarme),    24'h0);
    check("reset_fim",      24'(fim),       24'h0);
    check("reset_load_err", 24'(load_err),  24'h0);

    // Directed vector table.
    for (int i = 0; i < 17; i++) begin
      pulse(1'b0, vecs[i].clr, vecs[i].ld, vecs[i].sp, vecs[i].val);
      check($sformatf("vec%0d_load_err", i), 24'(load_err), 24'(vecs[i].exp_lerr));
      idle(vecs[i].wait_n);
      check($sformatf("vec%0d_digits", i),  digits(),      vecs[i].exp_digits);
      check($sformatf("vec%0d_running", i), 24'(running),  24'(vecs[i].exp_run));
      check($sformatf("vec%0d_alarme", i),  24'(alarme),   24'(vecs[i].exp_alarm));
    end

    // Pause two cycles after start, resume later: decrement two cycles after resume.
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 24'h000005);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
    idle(1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
    check("pause_running", 24'(running), 24'h0);
    idle(10);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
    check("resume_running", 24'(running), 24'h1);
    idle(1);
    check("resume_plus1", digits(), 24'h000005);
    idle(1);
    check("resume_plus2", digits(), 24'h000004);

    // start_pause on the tick cycle pauses without decrementing.
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 24'h000005);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
    idle(3);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
    check("tick_pause_digits",  digits(),     24'h000005);
    check("tick_pause_running", 24'(running), 24'h0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
    idle(3);
    check("tick_resume_hold", digits(), 24'h000005);
    idle(1);
    check("tick_resume_dec", digits(), 24'h000004);

    // fim pulses exactly once; start_pause in DONE silences the alarm.
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 24'h000001);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
    fim_count = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (fim) fim_count++;
    end
    check("fim_once",      24'(fim_count), 24'd1);
    check("done_alarme",   24'(alarme),    24'h1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
    check("done_sp_alarme", 24'(alarme),   24'h0);
    check("done_sp_digits", digits(),      24'h000000);

    // Reset in the middle of RUN; no stale tick afterwards.
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 24'h000009);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
    idle(2);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
    check("midrun_rst_digits",  digits(),     24'h000000);
    check("midrun_rst_running", 24'(running), 24'h0);
    idle(6);
    check("midrun_rst_hold", digits(), 24'h000000);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [23:0] v;
      int sel, ht;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
        v = 24'($urandom);
      end else if (sel == 1) begin
        ht = int'($urandom_range(0, 2));
        v = {4'(ht), 4'($urandom_range(0, (ht == 2) ? 3 : 9)),
             4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      end else begin
        v = {20'd0, 4'($urandom_range(0, 9))};
      end
      pulse(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_regressivo.md
# timer_regressivo

Countdown timer core producing the six BCD digits displayed in timer mode. Loads a start value from the timer-adjust digits and counts down once per second from a prescaled system clock. Raises an alarm at 00:00:00. Its digit outputs feed the display digit selector's timer-mode inputs, and its alarm output goes to the buzzer/LED logic.

## Interface
- CLK_HZ, 50_000_000: clk frequency; the prescaler period in cycles.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle pulse: copy ajuste_timer_* into the counter.
- start_pause  in  1  single-cycle pulse: start/resume/pause toggle.
- clear  in  1  single-cycle pulse: zero the counter, return to IDLE, silence the alarm.
- ajuste_timer_hour_tens, ajuste_timer_hour_units, ajuste_timer_min_tens, ajuste_timer_min_units, ajuste_timer_sec_tens, ajuste_timer_sec_units  in  4 each  BCD load value.
- hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units  out  4 each  current count, BCD, registered.
- running  out  1  high in RUN.
- alarme  out  1  high in DONE.
- fim  out  1  one-cycle pulse on entry to DONE.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - start_pause with nonzero count -> RUN; prescaler cleared to 0.
  - start_pause with a zero count is ignored.
- RUN:
  - On each prescaler tick, decrement the count.
  - start_pause -> PAUSE; prescaler phase is held.
- PAUSE:
  - start_pause -> RUN; the prescaler resumes from its held value.
- DONE:
  - Count reads 00:00:00 and alarme is high.
  - start_pause -> IDLE and silences the alarm.
- clear in any state -> IDLE; digits 0, prescaler 0, alarme 0.
- Load rules:
  - load is accepted in IDLE, PAUSE and DONE, and the next state is IDLE.
  - load in RUN is ignored and does not pulse load_err.
- Load validation, all of these must hold:
  - every digit ≤ 9;
  - min_tens ≤ 5 and sec_tens ≤ 5;
  - hour value ≤ 23, i.e. hour_tens ≤ 2 and, when hour_tens = 2, hour_units ≤ 3.
- An invalid load leaves count and state unchanged and pulses load_err.
- Decrement is BCD with borrow chain:
  - sec_units 0 -> 9, borrowing from sec_tens;
  - sec_tens 0 -> 5, borrowing from min_units;
  - min_units 0 -> 9, borrowing from min_tens;
  - min_tens 0 -> 5, borrowing from hour_units;
  - hour_units 0 -> 9, borrowing from hour_tens.
- The tick that produces 00:00:00 also moves the FSM to DONE. The count never wraps below zero.
- Event priority within one cycle: rst > clear > load > start_pause > tick.
  - A start_pause coinciding with a tick in RUN pauses the timer; the tick is discarded and the count is unchanged.

## Timing
- Reset values:
  - all digit outputs 0;
  - state IDLE;
  - running, alarme, fim and load_err all 0;
  - prescaler 0.
- Prescaler:
  - counts 0..CLK_HZ-1 while in RUN;
  - tick is asserted when the count equals CLK_HZ-1, and the counter wraps to 0 in that cycle.
- Latencies:
  - First decrement happens CLK_HZ cycles after the start_pause that entered RUN from IDLE.
  - Digit outputs update on the clock edge following the tick cycle (1-cycle latency).
  - A load is visible on the outputs one cycle after the pulse.
  - running, alarme and the new state change on the same edge as the causing event.
  - fim pulses in the first cycle of DONE; load_err pulses in the cycle after the rejected load.
- Reset mid-RUN takes effect at the next edge; no pending tick survives it.

## Structure
- Package timer_pkg:
  - state enum timer_state_t {IDLE, RUN, PAUSE, DONE};
  - BCD limit constants MAX_UNITS = 9, MAX_TENS_MS = 5, MAX_HOUR = 23;
  - a function bcd_dec for one digit returning {borrow, digit}.
- Sub-module divisor_1hz (parameter CLK_HZ; inputs clk, rst, en, clr; output tick) holds the prescaler.
- The FSM, load validation and borrow chain live in timer_regressivo.

## Test plan
All scenarios run with CLK_HZ = 4.
- Reset: assert rst for 2 cycles -> all digits 0, state IDLE, running/alarme/fim/load_err all 0.
- Basic countdown: load 00:00:03, then start_pause -> sec_units reads 2, 1, 0 at 4-cycle intervals; fim pulses once; alarme held high until clear.
- Borrow chain: load 01:00:00 and run 1 tick -> 00:59:59. Load 20:00:00 and run 1 tick -> 19:59:59.
- Pause/resume phase: start, pause 2 cycles after start, wait 10 cycles, resume -> first decrement occurs 2 cycles after resume.
- Load rejection:
  - load 24:00:00 -> load_err pulse, count unchanged;
  - load 00:60:00 -> load_err pulse;
  - load during RUN -> ignored, no load_err.
- Collisions:
  - clear and load in the same cycle -> IDLE with 00:00:00;
  - start_pause on a tick cycle in RUN -> PAUSE with the count unchanged;
  - start_pause in IDLE with a zero count -> stays IDLE.
